// File: rtl/char_fifo_p_if.sv
// Handshake bundle between char_fifo_p and its producer/consumer.
// master drives requests and write data; slave is the FIFO side.
interface char_fifo_p_if #(
  parameter int DATA_WID = 8,
  parameter int DEPL2    = 3
);
  logic                push;
  logic                pop;
  logic                flush;
  logic                clr_err;
  logic [DATA_WID-1:0] data_in;
  logic [DATA_WID-1:0] data_out;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [DEPL2:0]      count;
  logic                overflow;
  logic                underflow;

  modport master (
    output push, pop, flush, clr_err, data_in,
    input  data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, clr_err, data_in,
    output data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/char_fifo_p.sv
// Parametrised character FIFO for the print path: full-depth occupancy count,
// programmable almost flags, FWFT or registered read, flush and sticky errors.
module char_fifo_p #(
  parameter int DATA_WID = 8,
  parameter int DEPL2    = 3,
  parameter int DEPTH    = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input logic          clk,
  input logic          rst,
  char_fifo_p_if.slave bus
);

  localparam logic [DEPL2:0]   FULL_CNT = (DEPL2+1)'(DEPTH);
  localparam logic [DEPL2:0]   AF_CNT   = (DEPL2+1)'(AF_LEVEL);
  localparam logic [DEPL2:0]   AE_CNT   = (DEPL2+1)'(AE_LEVEL);
  localparam logic [DEPL2:0]   CNT_ONE  = (DEPL2+1)'(1);
  localparam logic [DEPL2-1:0] PTR_ONE  = (DEPL2)'(1);

  logic [DATA_WID-1:0] mem [DEPTH];
  logic [DEPL2-1:0]    wr_ptr;
  logic [DEPL2-1:0]    rd_ptr;
  logic [DEPL2:0]      cnt;
  logic                ovf_q;
  logic                udf_q;

  logic full_c;
  logic empty_c;
  logic acc_push;
  logic acc_pop;
  logic do_push;
  logic do_pop;

  always_comb begin
    full_c   = (cnt == FULL_CNT);
    empty_c  = (cnt == '0);
    acc_pop  = bus.pop & ~empty_c;
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    acc_push = bus.push & (~full_c | bus.pop);
    do_push  = acc_push & ~bus.flush;
    do_pop   = acc_pop & ~bus.flush;
  end

  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (cnt >= AF_CNT);
  assign bus.almost_empty = (cnt <= AE_CNT);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  // Storage is deliberately not reset; rst and flush only move pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Flush suppresses requests entirely, so a flushed cycle cannot raise an error;
  // a new error wins over a simultaneous clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~bus.clr_err) | (~bus.flush & bus.push & ~acc_push);
      udf_q <= (udf_q & ~bus.clr_err) | (~bus.flush & bus.pop & ~acc_pop);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = empty_c ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [DATA_WID-1:0] dout_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
        end else if (do_pop) begin
          dout_q <= mem[rd_ptr];
        end
      end

      assign bus.data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_char_fifo_p.sv
// Directed bench for char_fifo_p: registered-read instance (dut_r) and FWFT instance (dut_f).
module tb_char_fifo_p;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  char_fifo_p_if #(.DATA_WID(8), .DEPL2(3)) a_if ();
  char_fifo_p_if #(.DATA_WID(8), .DEPL2(3)) b_if ();

  char_fifo_p #(
    .DATA_WID(8), .DEPL2(3), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)
  ) dut_r (
    .clk(clk),
    .rst(rst),
    .bus(a_if)
  );

  char_fifo_p #(
    .DATA_WID(8), .DEPL2(3), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)
  ) dut_f (
    .clk(clk),
    .rst(rst),
    .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock on the registered instance; inputs return to idle afterwards.
  task automatic step_a(input logic ps, input logic pp, input logic fl,
                        input logic ce, input logic [7:0] d);
    a_if.push = ps; a_if.pop = pp; a_if.flush = fl; a_if.clr_err = ce; a_if.data_in = d;
    @(posedge clk);
    #1;
    a_if.push = 1'b0; a_if.pop = 1'b0; a_if.flush = 1'b0; a_if.clr_err = 1'b0;
  endtask

  task automatic step_b(input logic ps, input logic pp, input logic [7:0] d);
    b_if.push = ps; b_if.pop = pp; b_if.data_in = d;
    @(posedge clk);
    #1;
    b_if.push = 1'b0; b_if.pop = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    a_if.push = 1'b0; a_if.pop = 1'b0; a_if.flush = 1'b0; a_if.clr_err = 1'b0;
    a_if.data_in = '0;
    b_if.push = 1'b0; b_if.pop = 1'b0; b_if.flush = 1'b0; b_if.clr_err = 1'b0;
    b_if.data_in = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_count", a_if.count, 4'd0);
    check("rst_empty", a_if.empty, 1'b1);
    check("rst_full", a_if.full, 1'b0);
    check("rst_af", a_if.almost_full, 1'b0);
    check("rst_ae", a_if.almost_empty, 1'b1);
    check("rst_dout", a_if.data_out, 8'h00);
    check("rst_ovf", a_if.overflow, 1'b0);
    check("rst_udf", a_if.underflow, 1'b0);
    check("rst_f_dout", b_if.data_out, 8'h00);
    rst = 1'b0;

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      check("fill_count", a_if.count, 64'(i));
      check("fill_af", a_if.almost_full, (i >= 6) ? 1'b1 : 1'b0);
      check("fill_ae", a_if.almost_empty, (i <= 1) ? 1'b1 : 1'b0);
    end
    check("fill_full", a_if.full, 1'b1);
    check("fill_empty", a_if.empty, 1'b0);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("drain_dout", a_if.data_out, 64'(i));
      check("drain_count", a_if.count, 64'(8 - i));
    end
    check("drain_empty", a_if.empty, 1'b1);
    check("drain_udf", a_if.underflow, 1'b0);

    // Overflow and pointer wrap
    for (int i = 0; i < 8; i++) step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h11 + i));
    step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    check("ovf_flag", a_if.overflow, 1'b1);
    check("ovf_count", a_if.count, 4'd8);
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("wrap_pop", a_if.data_out, 64'(8'h11 + i));
    end
    for (int i = 0; i < 3; i++) step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h21 + i));
    check("wrap_count", a_if.count, 4'd8);
    check("ovf_sticky", a_if.overflow, 1'b1);
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("ovf_clr", a_if.overflow, 1'b0);

    // Push+pop while full
    step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'h24);
    check("pp_full_dout", a_if.data_out, 8'h14);
    check("pp_full_count", a_if.count, 4'd8);
    check("pp_full_ovf", a_if.overflow, 1'b0);
    begin
      logic [7:0] exp_q [8];
      exp_q = '{8'h15, 8'h16, 8'h17, 8'h18, 8'h21, 8'h22, 8'h23, 8'h24};
      for (int i = 0; i < 8; i++) begin
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap_drain", a_if.data_out, 64'(exp_q[i]));
      end
    end
    check("wrap_empty", a_if.empty, 1'b1);

    // Push+pop while empty
    step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'h31);
    check("pp_empty_count", a_if.count, 4'd1);
    check("pp_empty_udf", a_if.underflow, 1'b1);
    check("pp_empty_dout", a_if.data_out, 8'h24);
    step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("pp_empty_pop", a_if.data_out, 8'h31);
    step_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("udf_clr", a_if.underflow, 1'b0);

    // clr_err together with a new error keeps the flag set
    step_a(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    check("udf_clr_race", a_if.underflow, 1'b1);
    check("udf_hold_dout", a_if.data_out, 8'h31);

    // Flush with simultaneous push
    for (int i = 0; i < 5; i++) step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h41 + i));
    step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("pre_flush_dout", a_if.data_out, 8'h41);
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
    check("flush_count", a_if.count, 4'd0);
    check("flush_empty", a_if.empty, 1'b1);
    check("flush_udf", a_if.underflow, 1'b1);
    check("flush_ovf", a_if.overflow, 1'b0);
    check("flush_dout", a_if.data_out, 8'h41);
    step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h51);
    check("post_flush_count", a_if.count, 4'd1);
    step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("post_flush_dout", a_if.data_out, 8'h51);

    // Asynchronous reset between edges
    for (int i = 0; i < 4; i++) step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h61 + i));
    step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("pre_rst_dout", a_if.data_out, 8'h61);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", a_if.count, 4'd0);
    check("arst_empty", a_if.empty, 1'b1);
    check("arst_dout", a_if.data_out, 8'h00);
    check("arst_udf", a_if.underflow, 1'b0);
    rst = 1'b0;
    #3;
    step_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h71);
    check("post_rst_count", a_if.count, 4'd1);
    step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("post_rst_dout", a_if.data_out, 8'h71);
    check("post_rst_empty", a_if.empty, 1'b1);

    // FWFT instance
    check("fwft_idle", b_if.data_out, 8'h00);
    step_b(1'b1, 1'b0, 8'hA5);
    check("fwft_show", b_if.data_out, 8'hA5);
    check("fwft_count", b_if.count, 4'd1);
    step_b(1'b0, 1'b1, 8'h00);
    check("fwft_pop_dout", b_if.data_out, 8'h00);
    check("fwft_pop_empty", b_if.empty, 1'b1);
    step_b(1'b1, 1'b0, 8'hB1);
    step_b(1'b1, 1'b0, 8'hB2);
    check("fwft_head", b_if.data_out, 8'hB1);
    step_b(1'b0, 1'b1, 8'h00);
    check("fwft_next", b_if.data_out, 8'hB2);
    step_b(1'b0, 1'b1, 8'h00);
    check("fwft_drained", b_if.data_out, 8'h00);
    check("fwft_udf", b_if.underflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
